// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the pong game controller and its consumers (render, ball logic).
package game_ctrl_pkg;

  // Game state encoding driven directly on game_state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam int unsigned STATE_W       = 2;
  localparam int unsigned SCORE_W       = 4;
  localparam int unsigned CNT_W         = 10;
  localparam int unsigned DEF_SERVE_MS  = 1000;
  localparam int unsigned DEF_WIN_SCORE = 5;

endpackage

// File: rtl/game_ctrl_rise_detect.sv
// Registered rising-edge detector: o_rise pulses one cycle after i_sig goes high.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;
  logic r_rise;

  // Track previous level; during reset load the live level so a held-high input gives no event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= i_sig;
      r_rise <= 1'b0;
    end else begin
      r_prev <= i_sig;
      r_rise <= i_sig & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/game_ctrl.sv
// Pong game controller: serve delay, scoring, win detection and ball gating.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned SERVE_MS  = DEF_SERVE_MS,
  parameter int unsigned WIN_SCORE = DEF_WIN_SCORE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_1ms,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic [STATE_W-1:0] game_state,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               ball_reset,
  output logic               ball_enable,
  output logic               serve_dir,
  output logic               winner
);

  game_state_e        r_state;
  game_state_e        w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic [SCORE_W-1:0] w_score1_nxt;
  logic [SCORE_W-1:0] w_score2_nxt;
  logic [SCORE_W-1:0] w_score1_inc;
  logic [SCORE_W-1:0] w_score2_inc;
  logic               r_serve_dir;
  logic               w_serve_dir_nxt;
  logic               r_winner;
  logic               w_winner_nxt;
  logic               r_ball_reset;
  logic               r_ball_enable;
  logic               w_tick;
  logic               w_start_ev;

  rise_detect u_tick_det (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (clk_1ms),
    .o_rise (w_tick)
  );

  rise_detect u_start_det (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (start),
    .o_rise (w_start_ev)
  );

  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_score1_inc = r_score1 + SCORE_W'(1);
  assign w_score2_inc = r_score2 + SCORE_W'(1);

  // Next-state, counter and score decisions.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_score1_nxt    = r_score1;
    w_score2_nxt    = r_score2;
    w_serve_dir_nxt = r_serve_dir;
    w_winner_nxt    = r_winner;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ev) begin
          w_state_nxt = ST_SERVE;
          w_cnt_nxt   = '0;
        end
      end
      ST_SERVE: begin
        if (w_tick) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(SERVE_MS)) begin
            w_state_nxt = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        if (miss_left && miss_right) begin
          // Simultaneous miss is a replay: no point awarded.
          w_state_nxt = ST_SERVE;
          w_cnt_nxt   = '0;
        end else if (miss_right) begin
          w_score1_nxt    = w_score1_inc;
          w_serve_dir_nxt = 1'b1;
          w_cnt_nxt       = '0;
          if (w_score1_inc == SCORE_W'(WIN_SCORE)) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_SERVE;
          end
        end else if (miss_left) begin
          w_score2_nxt    = w_score2_inc;
          w_serve_dir_nxt = 1'b0;
          w_cnt_nxt       = '0;
          if (w_score2_inc == SCORE_W'(WIN_SCORE)) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_SERVE;
          end
        end
      end
      ST_OVER: begin
        if (w_start_ev) begin
          w_state_nxt     = ST_SERVE;
          w_cnt_nxt       = '0;
          w_score1_nxt    = '0;
          w_score2_nxt    = '0;
          w_serve_dir_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; ball gating follows the next state so it lines up with game_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_score1      <= '0;
      r_score2      <= '0;
      r_serve_dir   <= 1'b0;
      r_winner      <= 1'b0;
      r_ball_reset  <= 1'b1;
      r_ball_enable <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_score1      <= w_score1_nxt;
      r_score2      <= w_score2_nxt;
      r_serve_dir   <= w_serve_dir_nxt;
      r_winner      <= w_winner_nxt;
      r_ball_reset  <= (w_state_nxt != ST_PLAY);
      r_ball_enable <= (w_state_nxt == ST_PLAY);
    end
  end

  assign game_state  = STATE_W'(r_state);
  assign score1      = r_score1;
  assign score2      = r_score2;
  assign ball_reset  = r_ball_reset;
  assign ball_enable = r_ball_enable;
  assign serve_dir   = r_serve_dir;
  assign winner      = r_winner;

endmodule
